// File: rtl/maze_path_checker.sv
// maze_path_checker: replays a solver move stream against the wall map.
// Starting at (0,0) it walks one move at a time, reads the target cell
// through a synchronous read port, and flags boundary or wall violations.
// At the end of the stream it reports whether the walk finished on the goal.
//
// Handshake: a move is transferred on a rising edge where move_valid and
// move_ready are both high. move_ready depends only on the FSM state, never
// on move_valid. While move_ready is low the move inputs are ignored, and the
// producer holds move/move_last stable until the transfer completes.
module maze_path_checker #(
    parameter logic [3:0] GOAL_X = 4'd15,
    parameter logic [3:0] GOAL_Y = 4'd15,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             move_valid,
    input  logic [1:0]       move,
    input  logic             move_last,
    output logic             move_ready,
    output logic             rd_en,
    output logic [7:0]       rd_addr,
    input  logic             rd_data,
    output logic [3:0]       X,
    output logic [3:0]       Y,
    output logic [CNT_W-1:0] move_count,
    output logic             busy,
    output logic             done,
    output logic             success,
    output logic [1:0]       error_code,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        FETCH     = 3'd2,
        CHECK     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] hold_move;
    logic       hold_last;
    logic [3:0] cand_x;
    logic [3:0] cand_y;
    logic       oob;

    assign state_dbg = state;

    // Candidate position for the held move, plus carry/borrow detection.
    // X/Y do not change between FETCH and CHECK, so the same value serves both.
    always_comb begin
        cand_x = X;
        cand_y = Y;
        oob    = 1'b0;
        case (hold_move)
            2'b00: begin
                oob    = (Y == 4'd15);
                cand_y = Y + 4'd1;
            end
            2'b01: begin
                oob    = (X == 4'd15);
                cand_x = X + 4'd1;
            end
            2'b10: begin
                oob    = (X == 4'd0);
                cand_x = X - 4'd1;
            end
            default: begin
                oob    = (Y == 4'd0);
                cand_y = Y - 4'd1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nx   = state;
        move_ready = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = 8'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = WAIT_MOVE;
            end
            WAIT_MOVE: begin
                move_ready = 1'b1;
                busy       = 1'b1;
                if (move_valid) state_nx = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (oob) begin
                    state_nx = DONE;
                end else begin
                    rd_en    = 1'b1;
                    rd_addr  = {cand_y, cand_x};
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (rd_data || hold_last) begin
                    state_nx = DONE;
                end else begin
                    state_nx = WAIT_MOVE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = WAIT_MOVE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Position, counter, held move and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            X          <= 4'd0;
            Y          <= 4'd0;
            move_count <= '0;
            hold_move  <= 2'b00;
            hold_last  <= 1'b0;
            success    <= 1'b0;
            error_code <= 2'b00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        X          <= 4'd0;
                        Y          <= 4'd0;
                        move_count <= '0;
                        success    <= 1'b0;
                        error_code <= 2'b00;
                    end
                end
                WAIT_MOVE: begin
                    if (move_valid) begin
                        hold_move <= move;
                        hold_last <= move_last;
                    end
                end
                FETCH: begin
                    if (oob) error_code <= 2'b01;
                end
                CHECK: begin
                    if (rd_data) begin
                        error_code <= 2'b10;
                    end else begin
                        X <= cand_x;
                        Y <= cand_y;
                        if (move_count != {CNT_W{1'b1}}) begin
                            move_count <= move_count + CNT_W'(1);
                        end
                        if (hold_last) begin
                            if ((cand_x == GOAL_X) && (cand_y == GOAL_Y)) begin
                                success <= 1'b1;
                            end else begin
                                error_code <= 2'b11;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_path_checker.sv
// Testbench for maze_path_checker: table of single-move vectors over a small
// wall map, plus hand-written sequences for timing and control corner cases.
module tb_maze_path_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       move_valid;
    logic [1:0] move;
    logic       move_last;
    logic       move_ready;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       rd_data;
    logic [3:0] X;
    logic [3:0] Y;
    logic [7:0] move_count;
    logic       busy;
    logic       done;
    logic       success;
    logic [1:0] error_code;
    logic [2:0] state_dbg;

    int n_vec   = 0;
    int n_miss  = 0;
    int rd_pulses = 0;

    logic [7:0] exp_q[$];
    logic       wall_map [0:255];

    maze_path_checker #(.GOAL_X(4'd15), .GOAL_Y(4'd15), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .move_valid(move_valid), .move(move), .move_last(move_last),
        .move_ready(move_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .X(X), .Y(Y), .move_count(move_count),
        .busy(busy), .done(done), .success(success),
        .error_code(error_code), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) rd_data <= 1'b0;
        else if (rd_en) rd_data <= wall_map[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every read strobe must match the next expected address.
    always @(negedge clk) begin
        if (rd_en) begin
            rd_pulses++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rd_unexpected: got addr 0x%0h expected no read", rd_addr);
            end else begin
                check("rd_addr", rd_addr, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_map();
        for (int i = 0; i < 256; i++) wall_map[i] = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] m, input logic l);
        int t;
        t = 0;
        while (!move_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!move_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        move_valid = 1'b1;
        move       = m;
        move_last  = l;
        @(negedge clk);
        move_valid = 1'b0;
        move_last  = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(move_ready || done) && t < 10);
        if (!(move_ready || done)) check("move_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       st;
        logic [1:0] mv;
        logic       last;
        logic       rd;
        logic [7:0] addr;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [7:0] ecnt;
        logic       edone;
        logic       esucc;
        logic [1:0] eerr;
    } vec_t;

    function automatic vec_t mk(logic st, logic [1:0] mv, logic last, logic rd,
                                logic [7:0] addr, logic [3:0] ex, logic [3:0] ey,
                                logic [7:0] ecnt, logic edone, logic esucc, logic [1:0] eerr);
        vec_t v;
        v.st = st; v.mv = mv; v.last = last; v.rd = rd; v.addr = addr;
        v.ex = ex; v.ey = ey; v.ecnt = ecnt;
        v.edone = edone; v.esucc = esucc; v.eerr = eerr;
        return v;
    endfunction

    vec_t vecs [16];

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        rst = 1'b1; start = 1'b0; move_valid = 1'b0; move = 2'b00; move_last = 1'b0;
        clear_map();

        // Walls at (1,1) and (2,2).
        vecs[0]  = mk(1, 2'b00, 0, 1, 8'h10, 0, 1, 1, 0, 0, 2'b00);
        vecs[1]  = mk(0, 2'b01, 0, 1, 8'h11, 0, 1, 1, 1, 0, 2'b10);
        vecs[2]  = mk(1, 2'b01, 0, 1, 8'h01, 1, 0, 1, 0, 0, 2'b00);
        vecs[3]  = mk(0, 2'b01, 0, 1, 8'h02, 2, 0, 2, 0, 0, 2'b00);
        vecs[4]  = mk(0, 2'b00, 0, 1, 8'h12, 2, 1, 3, 0, 0, 2'b00);
        vecs[5]  = mk(0, 2'b11, 0, 1, 8'h02, 2, 0, 4, 0, 0, 2'b00);
        vecs[6]  = mk(0, 2'b10, 0, 1, 8'h01, 1, 0, 5, 0, 0, 2'b00);
        vecs[7]  = mk(0, 2'b10, 1, 1, 8'h00, 0, 0, 6, 1, 0, 2'b11);
        vecs[8]  = mk(1, 2'b11, 0, 0, 8'h00, 0, 0, 0, 1, 0, 2'b01);
        vecs[9]  = mk(1, 2'b10, 1, 0, 8'h00, 0, 0, 0, 1, 0, 2'b01);
        vecs[10] = mk(1, 2'b00, 0, 1, 8'h10, 0, 1, 1, 0, 0, 2'b00);
        vecs[11] = mk(0, 2'b00, 1, 1, 8'h20, 0, 2, 2, 1, 0, 2'b11);
        vecs[12] = mk(1, 2'b00, 0, 1, 8'h10, 0, 1, 1, 0, 0, 2'b00);
        vecs[13] = mk(0, 2'b00, 0, 1, 8'h20, 0, 2, 2, 0, 0, 2'b00);
        vecs[14] = mk(0, 2'b01, 0, 1, 8'h21, 1, 2, 3, 0, 0, 2'b00);
        vecs[15] = mk(0, 2'b01, 0, 1, 8'h22, 1, 2, 3, 1, 0, 2'b10);

        // Reset values while rst is held.
        #1;
        check("rst_x", X, 0);            check("rst_y", Y, 0);
        check("rst_cnt", move_count, 0); check("rst_ready", move_ready, 0);
        check("rst_rd_en", rd_en, 0);    check("rst_rd_addr", rd_addr, 0);
        check("rst_busy", busy, 0);      check("rst_done", done, 0);
        check("rst_succ", success, 0);   check("rst_err", error_code, 0);
        check("rst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", move_ready, 0);

        // Table-driven single moves.
        wall_map[8'h11] = 1'b1;
        wall_map[8'h22] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].st) pulse_start();
            if (vecs[i].rd) exp_q.push_back(vecs[i].addr);
            p0 = rd_pulses;
            do_move(vecs[i].mv, vecs[i].last);
            check($sformatf("v%0d_x", i), X, vecs[i].ex);
            check($sformatf("v%0d_y", i), Y, vecs[i].ey);
            check($sformatf("v%0d_cnt", i), move_count, vecs[i].ecnt);
            check($sformatf("v%0d_done", i), done, vecs[i].edone);
            check($sformatf("v%0d_busy", i), busy, !vecs[i].edone);
            check($sformatf("v%0d_succ", i), success, vecs[i].esucc);
            check($sformatf("v%0d_err", i), error_code, vecs[i].eerr);
            check($sformatf("v%0d_rds", i), rd_pulses - p0, vecs[i].rd);
        end
        clear_map();

        // Full path to the goal: 15 x right then 15 x up.
        pulse_start();
        p0 = rd_pulses;
        for (int i = 1; i <= 15; i++) begin
            exp_q.push_back({4'd0, 4'(i)});
            do_move(2'b01, 1'b0);
        end
        for (int j = 1; j <= 15; j++) begin
            exp_q.push_back({4'(j), 4'hF});
            do_move(2'b00, (j == 15));
        end
        check("goal_done", done, 1);        check("goal_succ", success, 1);
        check("goal_err", error_code, 0);   check("goal_x", X, 15);
        check("goal_y", Y, 15);             check("goal_cnt", move_count, 30);
        check("goal_rds", rd_pulses - p0, 30);

        // Right edge: X=15 then one more right is out of bounds.
        pulse_start();
        for (int i = 1; i <= 15; i++) begin
            exp_q.push_back({4'd0, 4'(i)});
            do_move(2'b01, 1'b0);
        end
        p0 = rd_pulses;
        do_move(2'b01, 1'b0);
        check("edge_err", error_code, 1);   check("edge_x", X, 15);
        check("edge_cnt", move_count, 15);  check("edge_rds", rd_pulses - p0, 0);

        // First move left: done two cycles after acceptance, no read.
        pulse_start();
        p0 = rd_pulses;
        move_valid = 1'b1; move = 2'b10; move_last = 1'b0;
        @(negedge clk);
        move_valid = 1'b0;
        check("oob_n1_done", done, 0);
        @(negedge clk);
        check("oob_done", done, 1);         check("oob_err", error_code, 1);
        check("oob_x", X, 0);               check("oob_cnt", move_count, 0);
        check("oob_rds", rd_pulses - p0, 0);

        // Wall at 0x01 with move right.
        wall_map[8'h01] = 1'b1;
        pulse_start();
        exp_q.push_back(8'h01);
        move_valid = 1'b1; move = 2'b01; move_last = 1'b0;
        @(negedge clk);
        move_valid = 1'b0;
        check("wall_rd_en", rd_en, 1);      check("wall_rd_addr", rd_addr, 8'h01);
        @(negedge clk);
        check("wall_check_done", done, 0);
        @(negedge clk);
        check("wall_done", done, 1);        check("wall_err", error_code, 2);
        check("wall_x", X, 0);              check("wall_y", Y, 0);
        wall_map[8'h01] = 1'b0;

        // Single last move that ends off goal.
        pulse_start();
        exp_q.push_back(8'h01);
        do_move(2'b01, 1'b1);
        check("off_done", done, 1);         check("off_succ", success, 0);
        check("off_err", error_code, 3);    check("off_x", X, 1);
        check("off_cnt", move_count, 1);

        // Throughput with move_valid held high: ready every third cycle.
        pulse_start();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        move_valid = 1'b1; move = 2'b01; move_last = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k != 0) @(negedge clk);
            check($sformatf("thr_ready%0d", k), move_ready, (k % 3) == 0);
        end
        move_valid = 1'b0;
        @(negedge clk);
        check("thr_x", X, 3);               check("thr_cnt", move_count, 3);

        // Start mid-session is ignored.
        pulse_start();
        check("mid_x", X, 3);               check("mid_cnt", move_count, 3);
        check("mid_busy", busy, 1);         check("mid_done", done, 0);
        exp_q.push_back(8'h13);
        do_move(2'b00, 1'b1);
        check("mid_end_err", error_code, 3); check("mid_end_cnt", move_count, 4);

        // Reset asserted while in CHECK, between clock edges.
        pulse_start();
        exp_q.push_back(8'h01);
        move_valid = 1'b1; move = 2'b01; move_last = 1'b0;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        check("arst_in_check", state_dbg, 3);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);        check("arst_ready", move_ready, 0);
        check("arst_x", X, 0);              check("arst_cnt", move_count, 0);
        check("arst_done", done, 0);        check("arst_err", error_code, 0);
        check("arst_rd_en", rd_en, 0);      check("arst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b0;

        // Start in DONE restarts from (0,0).
        pulse_start();
        exp_q.push_back(8'h01);
        do_move(2'b01, 1'b1);
        check("pre_restart_x", X, 1);
        pulse_start();
        check("rs_x", X, 0);                check("rs_y", Y, 0);
        check("rs_cnt", move_count, 0);     check("rs_done", done, 0);
        check("rs_err", error_code, 0);     check("rs_busy", busy, 1);
        check("rs_ready", move_ready, 1);
        exp_q.push_back(8'h10);
        do_move(2'b00, 1'b0);
        check("rs_move_y", Y, 1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected end earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maze_path_checker.md
# maze_path_checker

Consumes the 2-bit move stream that the maze solver emits after a search and replays it against the maze wall map. It starts from (0,0) and re-walks the path one move at a time, checking every step for a grid-boundary violation or a wall hit. It reports whether the stream ends exactly on the goal cell. It sits downstream of the solver datapath's move read-out, acting as the reader of that path, and shares the maze memory through a dedicated synchronous read port.

## Interface
- GOAL_X, 4'd15, goal column
- GOAL_Y, 4'd15, goal row
- CNT_W, 8, width of the accepted-move counter
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a check session; honoured only in IDLE or DONE
- move_valid  in  1  move/move_last are valid
- move  in  2  00=Y+1, 01=X+1, 10=X-1, 11=Y-1 (solver encoding)
- move_last  in  1  marks the final move of the stream
- move_ready  out  1  checker can accept a move this cycle
- rd_en  out  1  maze memory read strobe
- rd_addr  out  8  {Y,X} of the cell being read
- rd_data  in  1  wall bit (1=wall), valid the cycle after rd_en
- X, Y  out  4 each  current committed position
- move_count  out  CNT_W  moves committed this session
- busy  out  1  session in progress
- done  out  1  session finished; held until next start or rst
- success  out  1  stream ended on (GOAL_X,GOAL_Y) with no error; valid when done
- error_code  out  2  00 none, 01 out of bounds, 10 wall hit, 11 stream ended off goal

## Operation
- States: IDLE, WAIT_MOVE, FETCH, CHECK, DONE. Reset state: IDLE.
- IDLE/DONE + start: clear X, Y, move_count, done, success, and error_code, then go to WAIT_MOVE.
- start in any other state is ignored.
- WAIT_MOVE: move_ready=1. On move_valid&move_ready:
  - latch move and move_last into hold registers;
  - go to FETCH.
- FETCH: compute the candidate position from X/Y and the held move in 4-bit unsigned arithmetic.
  - If the move would produce a carry out of 15 or a borrow below 0: error_code=01, go to DONE. No rd_en is issued.
  - Otherwise: rd_en=1, rd_addr={candY,candX}, go to CHECK.
- CHECK: sample rd_data.
  - rd_data=1: error_code=10, go to DONE. X/Y are unchanged.
  - rd_data=0: commit X/Y to the candidate and increment move_count, which saturates at 2^CNT_W-1 with no error.
  - Then, if held last=1: go to DONE. success=1 if the new position is the goal, else error_code=11.
  - If held last=0: go back to WAIT_MOVE.
- Passing through the goal before move_last is not terminal.
- DONE: done=1, busy=0. All results are held and further moves are not accepted.
- busy=1 in WAIT_MOVE, FETCH and CHECK.
- A rst assertion in any state forces the reset values immediately, regardless of clk.

## Timing
- Reset values: X=0, Y=0, move_count=0, move_ready=0, rd_en=0, rd_addr=0, busy=0, done=0, success=0, error_code=00.
- start sampled at edge T: move_ready=1 and busy=1 from T+1.
- Move accepted at edge A:
  - FETCH during cycle A→A+1: rd_en high for exactly that one cycle.
  - CHECK during the next cycle: rd_data sampled at edge A+2.
  - X/Y/move_count are updated after edge A+2, and move_ready returns after edge A+2.
- Throughput is one move per 3 cycles. move_ready is low in FETCH, CHECK, DONE and IDLE.
- Out-of-bounds move accepted at A: done=1 and error_code=01 after edge A+1. rd_en never asserts.
- Last or wall move accepted at A: done=1 after edge A+2.
- move, move_valid and move_last are ignored whenever move_ready=0. The producer must hold its data until the handshake completes.

## Test plan
- Empty map, start, then 15×01 followed by 15×00 with the last move flagged:
  - required: done=1, success=1, error_code=00, X=Y=15, move_count=30;
  - required: rd_en pulses exactly 30 times.
- Start, then a first move of 10: after 2 cycles, done=1, error_code=01, X=0, move_count=0, and rd_en is never asserted.
- Wall at addr 0x01, move 01: rd_en=1 with rd_addr=0x01, then done=1, error_code=10, X=0, Y=0.
- Empty map, a single move 01 with move_last=1: done=1, success=0, error_code=11, X=1, move_count=1.
- Throughput and control checks:
  - with move_valid held high, move_ready pulses once every 3 cycles;
  - a start pulsed mid-session is ignored, with state and count unchanged;
  - rst asserted in CHECK forces all outputs to their reset values with no clock edge;
  - start in DONE restarts cleanly from (0,0).
